// File: rtl/usb_buffer_pkg.sv
// Shared sizing and FSM encoding for the USB endpoint data buffer and its controller.
package usb_buffer_pkg;

   localparam int BUF_DEPTH = 64;
   localparam int OCC_W     = 7;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      HOST_FILL,
      TX_ACTIVE,
      RX_ACTIVE,
      RX_HOLD
   } buf_ctrl_state_t;

endpackage

// File: rtl/fifo_data_buffer.sv
// 64-byte endpoint FIFO: one store and one get per cycle, clear/flush empty it at once.
module fifo_data_buffer
   import usb_buffer_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             store_i,
   input  logic             get_i,
   input  logic             clear_i,
   input  logic             flush_i,
   input  logic [7:0]       wdata_i,
   output logic [7:0]       rdata_o,
   output logic [OCC_W-1:0] occupancy_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);

   logic [7:0]       mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] cnt_q, cnt_d;
   logic             do_st, do_gt;

   assign do_st = store_i && (cnt_q < OCC_FULL);
   assign do_gt = get_i && (cnt_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i || flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_st) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_gt) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_st, do_gt})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_st && !clear_i && !flush_i) mem[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o     = mem[rd_ptr_q];
   assign occupancy_o = cnt_q;

endmodule

// File: rtl/fifo_buffer_ctrl.sv
// Phase sequencer and access arbiter for the endpoint FIFO; gates every buffer strobe
// by phase and occupancy and reports rejected accesses as one-cycle error pulses.
module fifo_buffer_ctrl
   import usb_buffer_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             host_store,
   input  logic             host_get,
   input  logic             host_tx_commit,
   input  logic             host_clear,
   input  logic             rx_store,
   input  logic             rx_packet_done,
   input  logic             rx_packet_error,
   input  logic             tx_get,
   input  logic             tx_packet_done,
   input  logic [OCC_W-1:0] buffer_occupancy,
   output logic             store_tx_data,
   output logic             store_rx_packet_data,
   output logic             get_rx_data,
   output logic             get_tx_packet_data,
   output logic             clear,
   output logic             flush,
   output logic             tx_start,
   output logic [OCC_W-1:0] tx_byte_count,
   output logic             rx_busy,
   output logic             rx_data_avail,
   output logic             host_err,
   output logic             usb_err
);

   buf_ctrl_state_t  state_q, state_d;
   logic [OCC_W-1:0] tx_cnt_q, tx_cnt_d;
   logic             host_err_q, host_err_d;
   logic             usb_err_q, usb_err_d;
   logic             tx_start_q, tx_start_d;
   logic             st_tx_d, st_rx_d, gt_rx_d, gt_tx_d, clr_d, fls_d;
   logic             occ_nz, occ_full;

   assign occ_nz   = buffer_occupancy != '0;
   assign occ_full = buffer_occupancy >= OCC_FULL;

   always_comb begin
      state_d    = state_q;
      tx_cnt_d   = tx_cnt_q;
      host_err_d = 1'b0;
      usb_err_d  = 1'b0;
      tx_start_d = 1'b0;
      st_tx_d    = 1'b0;
      st_rx_d    = 1'b0;
      gt_rx_d    = 1'b0;
      gt_tx_d    = 1'b0;
      clr_d      = 1'b0;
      fls_d      = 1'b0;
      if (host_clear) begin
         clr_d    = 1'b1;
         state_d  = IDLE;
         tx_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rx_store) begin
                  st_rx_d = 1'b1;
                  state_d = RX_ACTIVE;
               end else if (host_store) begin
                  st_tx_d = 1'b1;
                  state_d = HOST_FILL;
               end
               host_err_d = (rx_store && host_store) || host_get || host_tx_commit;
               usb_err_d  = tx_get;
            end
            HOST_FILL: begin
               st_tx_d = host_store && !occ_full;
               if (host_tx_commit && occ_nz) begin
                  tx_cnt_d   = buffer_occupancy + {{(OCC_W-1){1'b0}}, st_tx_d};
                  tx_start_d = 1'b1;
                  state_d    = TX_ACTIVE;
               end
               host_err_d = (host_store && occ_full) || (host_tx_commit && !occ_nz) || host_get;
               usb_err_d  = tx_get;
            end
            TX_ACTIVE: begin
               gt_tx_d    = tx_get && occ_nz;
               usb_err_d  = tx_get && !occ_nz;
               host_err_d = host_store || host_get || host_tx_commit;
               if (tx_packet_done) begin
                  fls_d   = occ_nz;
                  state_d = IDLE;
               end
            end
            RX_ACTIVE: begin
               host_err_d = host_store || host_get || host_tx_commit;
               // A bad packet is discarded whole, even if its last byte arrives now.
               if (rx_packet_error) begin
                  fls_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  st_rx_d   = rx_store && !occ_full;
                  usb_err_d = rx_store && occ_full;
                  if (rx_packet_done) state_d = (occ_nz || st_rx_d) ? RX_HOLD : IDLE;
               end
            end
            RX_HOLD: begin
               gt_rx_d    = host_get && occ_nz;
               host_err_d = (host_get && !occ_nz) || host_store || host_tx_commit;
               if (gt_rx_d && buffer_occupancy == OCC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         tx_cnt_q   <= '0;
         host_err_q <= 1'b0;
         usb_err_q  <= 1'b0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_cnt_q   <= tx_cnt_d;
         host_err_q <= host_err_d;
         usb_err_q  <= usb_err_d;
         tx_start_q <= tx_start_d;
      end
   end

   // Strobes are combinational, so reset has to mask them directly.
   assign store_tx_data        = st_tx_d & n_rst;
   assign store_rx_packet_data = st_rx_d & n_rst;
   assign get_rx_data          = gt_rx_d & n_rst;
   assign get_tx_packet_data   = gt_tx_d & n_rst;
   assign clear                = clr_d & n_rst;
   assign flush                = fls_d & n_rst;

   assign tx_start      = tx_start_q;
   assign tx_byte_count = tx_cnt_q;
   assign host_err      = host_err_q;
   assign usb_err       = usb_err_q;
   assign rx_busy       = (state_q == HOST_FILL) || (state_q == TX_ACTIVE) || (state_q == RX_HOLD);
   assign rx_data_avail = (state_q == RX_HOLD);

endmodule
